// File: rtl/param_cache.sv
// param_cache: write-back, write-allocate cache with 1 or 2 ways and an LRU bit per set.
// Define PARAM_CACHE_STATS_EN to build the saturating hit/miss counters; otherwise they read as zero.
module param_cache #(
  parameter int ADDR_W      = 8,
  parameter int WORD_W      = 8,
  parameter int OFFSET_BITS = 2,
  parameter int INDEX_BITS  = 3,
  parameter int WAYS        = 2
)(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              u_request,
  input  logic                              u_we,
  input  logic [ADDR_W-1:0]                 u_addr,
  input  logic [WORD_W-1:0]                 u_din,
  output logic                              u_ready,
  output logic [WORD_W-1:0]                 u_dout,
  output logic                              d_request,
  output logic                              d_we,
  output logic [ADDR_W-OFFSET_BITS-1:0]     d_addr,
  output logic [(WORD_W<<OFFSET_BITS)-1:0]  d_din,
  input  logic                              d_ready,
  input  logic [(WORD_W<<OFFSET_BITS)-1:0]  d_dout,
  output logic [15:0]                       hit_count,
  output logic [15:0]                       miss_count
);
  localparam int BLK_W = WORD_W << OFFSET_BITS;
  localparam int SETS  = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - OFFSET_BITS - INDEX_BITS;
  localparam logic [1:0] IDLE = 2'd0, COMPARE = 2'd1, WRITEBACK = 2'd2, ALLOCATE = 2'd3;
  logic [1:0]              r_state;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_we;
  logic [WORD_W-1:0]       r_din;
  logic                    r_victim;
  logic [BLK_W-1:0]        r_data  [WAYS][SETS];
  logic [TAG_W-1:0]        r_tag   [WAYS][SETS];
  logic [SETS-1:0]         r_valid [WAYS];
  logic [SETS-1:0]         r_dirty [WAYS];
  logic [SETS-1:0]         r_lru;
  logic [OFFSET_BITS-1:0]  w_off;
  logic [INDEX_BITS-1:0]   w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_hit, w_hway, w_vway, w_accept, w_fill;
  logic [WORD_W-1:0]       w_word;
  assign w_off    = r_addr[OFFSET_BITS-1:0];
  assign w_idx    = r_addr[OFFSET_BITS +: INDEX_BITS];
  assign w_tag    = r_addr[ADDR_W-1 -: TAG_W];
  assign w_word   = r_data[w_hway][w_idx][w_off*WORD_W +: WORD_W];
  assign w_accept = (r_state == IDLE) && u_request;
  assign w_fill   = (r_state == ALLOCATE) && d_request && d_ready;
  // Walking down from the top way lets way 0 win when several ways are invalid.
  always_comb begin
    w_hit  = 1'b0;
    w_hway = 1'b0;
    w_vway = (WAYS == 2) ? r_lru[w_idx] : 1'b0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
        w_hit  = 1'b1;
        w_hway = w[0];
      end
      if (!r_valid[w][w_idx]) w_vway = w[0];
    end
  end
  always_ff @(posedge clk) begin
    u_ready <= 1'b0;
    if (rst) begin
      r_state   <= IDLE;
      r_lru     <= '0;
      u_dout    <= '0;
      d_request <= 1'b0;
      d_we      <= 1'b0;
      d_addr    <= '0;
      d_din     <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_addr  <= u_addr;
          r_we    <= u_we;
          r_din   <= u_din;
          r_state <= COMPARE;
        end
        COMPARE: if (w_hit) begin
          u_ready <= 1'b1;
          if (r_we) begin
            r_data[w_hway][w_idx][w_off*WORD_W +: WORD_W] <= r_din;
            r_dirty[w_hway][w_idx] <= 1'b1;
          end else u_dout <= w_word;
          r_lru[w_idx] <= ~w_hway;
          r_state      <= IDLE;
        end else begin
          r_victim <= w_vway;
          if (r_valid[w_vway][w_idx] && r_dirty[w_vway][w_idx]) begin
            d_request <= 1'b1;
            d_we      <= 1'b1;
            d_addr    <= {r_tag[w_vway][w_idx], w_idx};
            d_din     <= r_data[w_vway][w_idx];
            r_state   <= WRITEBACK;
          end else r_state <= ALLOCATE;
        end
        WRITEBACK: if (d_ready) begin
          d_request <= 1'b0;
          r_state   <= ALLOCATE;
        end
        // Entering with d_request low guarantees the idle cycle between downstream requests.
        ALLOCATE: if (!d_request) begin
          d_request <= 1'b1;
          d_we      <= 1'b0;
          d_addr    <= r_addr[ADDR_W-1:OFFSET_BITS];
        end else if (d_ready) begin
          d_request                <= 1'b0;
          r_data[r_victim][w_idx]  <= d_dout;
          r_tag[r_victim][w_idx]   <= w_tag;
          r_valid[r_victim][w_idx] <= 1'b1;
          r_dirty[r_victim][w_idx] <= 1'b0;
          r_state                  <= COMPARE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef PARAM_CACHE_STATS_EN
  logic r_first;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_first    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      r_first <= w_accept ? 1'b1 : w_fill ? 1'b0 : r_first;
      if (r_state == COMPARE && w_hit && r_first && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (r_state == COMPARE && !w_hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_param_cache.sv
// tb_param_cache: vector table, directed corner sequences and random traffic for param_cache,
// checked against a per-set recency-list cache model and a byte-level reference memory.
`timescale 1ns/1ps
module tb_param_cache;
`ifdef PARAM_CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        u_request [2], u_we [2], u_ready [2], d_request [2], d_we [2], d_ready [2];
  logic [7:0]  u_addr [2], u_din [2], u_dout [2];
  logic [5:0]  d_addr [2];
  logic [31:0] d_din [2], d_dout [2];
  logic [15:0] hit_count [2], miss_count [2];
  param_cache #(.WAYS(2)) dut0 (
    .clk(clk), .rst(rst), .u_request(u_request[0]), .u_we(u_we[0]), .u_addr(u_addr[0]),
    .u_din(u_din[0]), .u_ready(u_ready[0]), .u_dout(u_dout[0]), .d_request(d_request[0]),
    .d_we(d_we[0]), .d_addr(d_addr[0]), .d_din(d_din[0]), .d_ready(d_ready[0]),
    .d_dout(d_dout[0]), .hit_count(hit_count[0]), .miss_count(miss_count[0]));
  param_cache #(.WAYS(1)) dut1 (
    .clk(clk), .rst(rst), .u_request(u_request[1]), .u_we(u_we[1]), .u_addr(u_addr[1]),
    .u_din(u_din[1]), .u_ready(u_ready[1]), .u_dout(u_dout[1]), .d_request(d_request[1]),
    .d_we(d_we[1]), .d_addr(d_addr[1]), .d_din(d_din[1]), .d_ready(d_ready[1]),
    .d_dout(d_dout[1]), .hit_count(hit_count[1]), .miss_count(miss_count[1]));

  // Downstream memory: answers dly cycles after seeing d_request, one-cycle d_ready.
  logic [31:0] mem [2][64];
  int          dly [2];
  int          nreq [2];
  int          cnt [2];
  logic [5:0]  wb_addr [2], rd_addr [2];
  logic [31:0] wb_din [2];
  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 64; b++) mem[k][b] = $urandom;
      mem[k][9]  = 32'h44332211;
      mem[k][1]  = 32'h88776655;
      mem[k][17] = 32'hDDCCBBAA;
      d_ready[k] = 1'b0; d_dout[k] = '0; cnt[k] = 0; nreq[k] = 0;
      wb_addr[k] = '0; rd_addr[k] = '0; wb_din[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst || d_ready[k] || !d_request[k]) begin
          d_ready[k] = 1'b0; cnt[k] = 0;
        end else begin
          cnt[k]++;
          if (cnt[k] >= dly[k]) begin
            if (d_we[k]) begin
              mem[k][d_addr[k]] = d_din[k];
              wb_addr[k] = d_addr[k];
              wb_din[k]  = d_din[k];
            end else rd_addr[k] = d_addr[k];
            d_dout[k]  = mem[k][d_addr[k]];
            d_ready[k] = 1'b1;
            nreq[k]++;
          end
        end
      end
    end
  end

  int         n_chk = 0, n_fail = 0;
  logic [7:0] ref_mem [2][256];
  int         q [2][8][$];
  int         exp_hit [2], exp_miss [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    for (int s = 0; s < 8; s++) q[k][s].delete();
    exp_hit[k] = 0; exp_miss[k] = 0;
    for (int a = 0; a < 256; a++) ref_mem[k][a] = mem[k][a>>2][(a%4)*8 +: 8];
  endtask

  // Resident blocks per set, least recently used first.
  function automatic bit model_access(input int k, input logic [7:0] a);
    int s = int'(a[4:2]);
    int t = int'(a[7:5]);
    int ways = (k == 0) ? 2 : 1;
    for (int i = 0; i < q[k][s].size(); i++)
      if (q[k][s][i] == t) begin
        q[k][s].delete(i);
        q[k][s].push_back(t);
        return 1'b1;
      end
    if (q[k][s].size() == ways) void'(q[k][s].pop_front());
    q[k][s].push_back(t);
    return 1'b0;
  endfunction

  task automatic do_req(input int k, input logic we, input logic [7:0] a, input logic [7:0] din,
                        output logic [7:0] dout, output logic hit);
    bit mhit;
    int lat, n0;
    logic was;
    logic [5:0] ca;
    logic [31:0] cd;
    logic cw;
    logic [7:0] old;
    mhit = model_access(k, a);
    if (mhit) exp_hit[k]++; else exp_miss[k]++;
    n0 = nreq[k]; lat = 0; was = 1'b0; ca = '0; cd = '0; cw = 1'b0;
    old = u_dout[k];
    u_request[k] = 1'b1; u_we[k] = we; u_addr[k] = a; u_din[k] = din;
    @(posedge clk); #1;
    u_request[k] = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (d_ready[k]) chk("d_request_drop", 32'(d_request[k]), 32'd0);
      if (d_request[k] && was) begin
        chk("d_addr_stable", 32'(d_addr[k]), 32'(ca));
        chk("d_din_stable", d_din[k], cd);
        chk("d_we_stable", 32'(d_we[k]), 32'(cw));
      end else if (d_request[k]) begin
        ca = d_addr[k]; cd = d_din[k]; cw = d_we[k];
      end
      was = d_request[k];
      if (!u_ready[k]) chk("u_dout_hold", 32'(u_dout[k]), 32'(old));
    end while (!u_ready[k] && lat < 200);
    chk("u_ready_seen", 32'(u_ready[k]), 32'd1);
    hit = (lat == 1) && (nreq[k] == n0);
    chk("hit_vs_model", 32'(hit), 32'(mhit));
    if (!mhit) chk("fill_before_ready", 32'(nreq[k] > n0), 32'd1);
    if (!we) chk("read_data", 32'(u_dout[k]), 32'(ref_mem[k][a]));
    else ref_mem[k][a] = din;
    dout = u_dout[k];
    @(posedge clk); #1;
    chk("u_ready_pulse", 32'(u_ready[k]), 32'd0);
    chk("u_dout_keep", 32'(u_dout[k]), 32'(dout));
    chk("hit_count", 32'(hit_count[k]), STATS ? 32'(exp_hit[k]) : 32'd0);
    chk("miss_count", 32'(miss_count[k]), STATS ? 32'(exp_miss[k]) : 32'd0);
  endtask

  task automatic chk_zero(input int k);
    chk("rst_u_ready", 32'(u_ready[k]), 32'd0);
    chk("rst_u_dout", 32'(u_dout[k]), 32'd0);
    chk("rst_d_request", 32'(d_request[k]), 32'd0);
    chk("rst_d_we", 32'(d_we[k]), 32'd0);
    chk("rst_d_addr", 32'(d_addr[k]), 32'd0);
    chk("rst_d_din", d_din[k], 32'd0);
    chk("rst_hit_count", 32'(hit_count[k]), 32'd0);
    chk("rst_miss_count", 32'(miss_count[k]), 32'd0);
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] din;
    logic       hit;
    logic [7:0] dout;
    logic [5:0] rblk;
  } vec_t;
  vec_t v [6];

  initial begin
    logic [7:0] dout;
    logic hit;
    int lat;
    v[0] = '{1'b0, 8'h25, 8'h00, 1'b0, 8'h22, 6'h09};
    v[1] = '{1'b0, 8'h24, 8'h00, 1'b1, 8'h11, 6'h00};
    v[2] = '{1'b1, 8'h25, 8'hAB, 1'b1, 8'h00, 6'h00};
    v[3] = '{1'b0, 8'h05, 8'h00, 1'b0, 8'h66, 6'h01};
    v[4] = '{1'b0, 8'h45, 8'h00, 1'b0, 8'hBB, 6'h11};
    v[5] = '{1'b0, 8'h25, 8'h00, 1'b0, 8'hAB, 6'h09};
    for (int k = 0; k < 2; k++) begin
      u_request[k] = 1'b0; u_we[k] = 1'b0; u_addr[k] = '0; u_din[k] = '0; dly[k] = 2;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk_zero(k);
      model_reset(k);
    end

    for (int i = 0; i < 6; i++) begin
      do_req(0, v[i].we, v[i].addr, v[i].din, dout, hit);
      chk("vec_hit", 32'(hit), 32'(v[i].hit));
      if (!v[i].we) chk("vec_dout", 32'(dout), 32'(v[i].dout));
      if (!v[i].hit) chk("vec_fill_addr", 32'(rd_addr[0]), 32'(v[i].rblk));
    end
    chk("wb_addr", 32'(wb_addr[0]), 32'h09);
    chk("wb_din", wb_din[0], 32'h4433AB11);

    dly[0] = 5;
    do_req(0, 1'b1, 8'h26, 8'h77, dout, hit);
    do_req(0, 1'b1, 8'h46, 8'h5C, dout, hit);
    do_req(0, 1'b0, 8'h86, 8'h00, dout, hit);
    chk("slow_miss", 32'(hit), 32'd0);
    chk("slow_wb_addr", 32'(wb_addr[0]), 32'h09);
    chk("slow_wb_din", wb_din[0], 32'h4477AB11);

    u_request[0] = 1'b1; u_we[0] = 1'b0; u_addr[0] = 8'hC5;
    @(posedge clk); #1;
    u_request[0] = 1'b0;
    lat = 0;
    while (!(d_request[0] && !d_we[0]) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("alloc_in_flight", 32'(d_request[0] && !d_we[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero(0);
    chk_zero(1);
    model_reset(0);
    model_reset(1);
    dly[0] = 2;
    do_req(0, 1'b0, 8'h25, 8'h00, dout, hit);
    chk("post_rst_miss", 32'(hit), 32'd0);
    chk("post_rst_dout", 32'(dout), 32'hAB);

    for (int i = 0; i < 8; i++) begin
      do_req(1, 1'b0, (i % 2 == 0) ? 8'h05 : 8'h25, 8'h00, dout, hit);
      chk("w1_alt_miss", 32'(hit), 32'd0);
    end
    chk("w1_hits", 32'(hit_count[1]), 32'd0);
    chk("w1_misses", 32'(miss_count[1]), STATS ? 32'd8 : 32'd0);

    for (int i = 0; i < 160; i++) begin
      dly[0] = int'($urandom_range(1, 4));
      do_req(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), 8'($urandom), dout, hit);
    end
    for (int i = 0; i < 40; i++) begin
      dly[1] = int'($urandom_range(1, 3));
      do_req(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 63)), 8'($urandom), dout, hit);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/param_cache.md
PARAM_CACHE -- requirements
Module: param_cache

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: byte-address width.
REQ-002 SHALL have parameter WORD_W, default 8: user data width.
REQ-003 SHALL have parameter OFFSET_BITS, default 2: log2 of words per block.
REQ-004 SHALL have parameter INDEX_BITS, default 3: log2 of sets.
REQ-005 SHALL have parameter WAYS, default 2: associativity; legal values 1 or 2.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-008 SHALL have ports u_request in 1, u_we in 1, u_addr in ADDR_W, u_din in WORD_W: user request, write enable, address, write data.
REQ-009 SHALL have ports u_ready out 1, u_dout out WORD_W: completion pulse and read data.
REQ-010 SHALL have ports d_request out 1, d_we out 1, d_addr out ADDR_W-OFFSET_BITS, d_din out WORD_W<<OFFSET_BITS: downstream block request.
REQ-011 SHALL have ports d_ready in 1, d_dout in WORD_W<<OFFSET_BITS: downstream completion and read block.
REQ-012 SHALL have ports hit_count out 16, miss_count out 16: statistics.

Function
REQ-013 SHALL split u_addr as offset = [OFFSET_BITS-1:0], index = next INDEX_BITS, tag = remaining MSBs; word w of a block occupies bits [WORD_W*(w+1)-1 : WORD_W*w].
REQ-014 SHALL be write-back, write-allocate, with per-line valid, dirty, tag; per-set LRU bit when WAYS=2.
REQ-015 SHALL implement FSM IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-016 IDLE: u_request=1 latches addr/we/din; next state COMPARE.
REQ-017 COMPARE hit: u_ready=1 for exactly that cycle (1 cycle after acceptance); read drives u_dout with the word; write stores u_din and sets dirty; LRU points to the other way; next IDLE.
REQ-018 COMPARE miss: victim = way 0 if WAYS=1; else first invalid way (way 0 preferred), else LRU way; victim valid and dirty -> WRITEBACK, otherwise -> ALLOCATE.
REQ-019 WRITEBACK: d_request=1, d_we=1, d_addr={victim tag,index}, d_din=victim block, held stable until d_ready sampled 1; then ALLOCATE.
REQ-020 ALLOCATE: d_request=1, d_we=0, d_addr={tag,index}, held until d_ready sampled 1; then store d_dout into victim, valid=1, dirty=0, and return to COMPARE, which then hits.
REQ-021 d_request SHALL drop in the cycle after d_ready is sampled; no back-to-back d_request without one low cycle.
REQ-022 u_dout SHALL hold its value except on read hit; u_request deasserted mid-transaction SHALL NOT abort it; u_ready still pulses.
REQ-023 A new request SHALL be accepted no earlier than the cycle after u_ready.

Reset
REQ-024 rst high at a clock edge SHALL force IDLE, clear all valid, dirty, LRU bits, zero u_ready, u_dout, d_request, d_we, d_addr, d_din, hit_count, miss_count; in-flight transaction and dirty data SHALL be discarded.
REQ-025 rst SHALL take priority over every other event, including d_ready in the same cycle.

Configuration
REQ-026 With macro PARAM_CACHE_STATS_EN defined, hit_count SHALL increment on each first-pass COMPARE hit and miss_count on each COMPARE miss, both saturating at 0xFFFF; the re-compare after ALLOCATE SHALL NOT count.
REQ-027 Without PARAM_CACHE_STATS_EN, hit_count and miss_count SHALL be tied to 0 and no counter logic synthesised.

Verification (defaults, PARAM_CACHE_STATS_EN defined, downstream model answers d_ready 2 cycles after d_request)
REQ-028 After reset, read 0x25 -> d_request, d_we=0, d_addr=0x09; d_dout=0x44332211 -> u_dout=0x22, u_ready one pulse, miss_count=1.
REQ-029 Then read 0x24 -> no d_request, u_ready 1 cycle after acceptance, u_dout=0x11, hit_count=1.
REQ-030 Write 0xAB to 0x25, read 0x05 (fills way 1), read 0x45 -> WRITEBACK d_we=1, d_addr=0x09, d_din=0x4433AB11, then ALLOCATE d_addr=0x11.
REQ-031 d_ready delayed 5 cycles -> d_request, d_addr, d_din stable all 5 cycles; u_ready not before fill completes.
REQ-032 rst pulsed during ALLOCATE with d_request=1 -> d_request=0 next cycle, all outputs zero; subsequent read 0x25 misses.
REQ-033 WAYS=1: alternate reads 0x05, 0x25 four times -> eight misses, hit_count=0.
